cardinal_nic_q: RTL

- Parametrised, queued successor of the single-slot cardinal NIC; connects one CPU's NIC port to one cardinal ring node.
- Each direction has a DEPTH-entry FIFO, so the CPU can post or drain several packets without a round trip per packet.
- Ring injection is gated by the ring's even/odd polarity, matched against the packet's VC bit.
- Drops into the cmp top level in place of the current NIC: same port roles, widths set by parameters.

---
 rtl/cardinal_nic_q.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/cardinal_nic_q.sv
// Queued cardinal NIC: DEPTH-entry FIFOs between a CPU register port and a ring node.
// Optional saturating rx/tx statistics counters are enabled by defining NIC_STATS_EN.
module cardinal_nic_q #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] d_out,
  input  logic              nicEn,
  input  logic              nicWrEn,
  input  logic              net_si,
  output logic              net_ri,
  input  logic [DATA_W-1:0] net_di,
  output logic              net_so,
  input  logic              net_ro,
  output logic [DATA_W-1:0] net_do,
  input  logic              net_polarity
);

  localparam int PTR_W    = $clog2(DEPTH);
  localparam int CNT_BITS = PTR_W + 1;
  localparam logic [CNT_BITS-1:0] FULL_CNT = CNT_BITS'(DEPTH);

  localparam logic [1:0] A_IN_DATA  = 2'b00;
  localparam logic [1:0] A_IN_STAT  = 2'b01;
  localparam logic [1:0] A_OUT_DATA = 2'b10;
  localparam logic [1:0] A_OUT_STAT = 2'b11;

  logic [DATA_W-1:0]   r_in_mem  [DEPTH];
  logic [DATA_W-1:0]   r_out_mem [DEPTH];
  logic [PTR_W-1:0]    r_in_wr, r_in_rd, r_out_wr, r_out_rd;
  logic [CNT_BITS-1:0] r_in_count, r_out_count;
  logic                r_net_so;
  logic [DATA_W-1:0]   r_net_do;

  logic              w_in_empty, w_in_full, w_out_empty, w_out_full;
  logic              w_cpu_rd, w_cpu_wr;
  logic              w_in_push, w_in_pop, w_out_push, w_inj;
  logic [DATA_W-1:0] w_in_head, w_out_head;
  logic [DATA_W-1:0] w_in_status, w_out_status;

  assign w_in_empty  = (r_in_count == '0);
  assign w_in_full   = (r_in_count == FULL_CNT);
  assign w_out_empty = (r_out_count == '0);
  assign w_out_full  = (r_out_count == FULL_CNT);

  assign w_cpu_rd = nicEn && !nicWrEn;
  assign w_cpu_wr = nicEn && nicWrEn;

  assign w_in_head  = r_in_mem[r_in_rd];
  assign w_out_head = r_out_mem[r_out_rd];

  // A ring delivery while full is a protocol violation and is simply ignored.
  assign w_in_push  = net_si && !w_in_full;
  assign w_in_pop   = w_cpu_rd && (addr == A_IN_DATA) && !w_in_empty;
  // Fullness is judged before the edge, so a write while full is lost even if
  // an injection frees a slot on the same edge.
  assign w_out_push = w_cpu_wr && (addr == A_OUT_DATA) && !w_out_full;
  assign w_inj      = !w_out_empty && net_ro && (w_out_head[DATA_W-1] == net_polarity);

  assign net_ri = !w_in_full;
  assign net_so = r_net_so;
  assign net_do = r_net_do;

  // NOTE: FIFO storage has no reset; the pointers and counts define which
  // entries are valid, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (w_in_push)  r_in_mem[r_in_wr]   <= net_di;
    if (w_out_push) r_out_mem[r_out_wr] <= d_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_in_wr    <= '0;
      r_in_rd    <= '0;
      r_in_count <= '0;
    end else begin
      if (w_in_push) r_in_wr <= r_in_wr + 1'b1;
      if (w_in_pop)  r_in_rd <= r_in_rd + 1'b1;
      case ({w_in_push, w_in_pop})
        2'b10:   r_in_count <= r_in_count + 1'b1;
        2'b01:   r_in_count <= r_in_count - 1'b1;
        default: r_in_count <= r_in_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_wr    <= '0;
      r_out_rd    <= '0;
      r_out_count <= '0;
    end else begin
      if (w_out_push) r_out_wr <= r_out_wr + 1'b1;
      if (w_inj)      r_out_rd <= r_out_rd + 1'b1;
      case ({w_out_push, w_inj})
        2'b10:   r_out_count <= r_out_count + 1'b1;
        2'b01:   r_out_count <= r_out_count - 1'b1;
        default: r_out_count <= r_out_count;
      endcase
    end
  end

  // net_do keeps the last injected packet between injections.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_net_so <= 1'b0;
      r_net_do <= '0;
    end else begin
      r_net_so <= w_inj;
      if (w_inj) r_net_do <= w_out_head;
    end
  end

`ifdef NIC_STATS_EN
  logic [CNT_W-1:0] r_rx_cnt, r_tx_cnt;
  logic             w_rx_clr, w_tx_clr;

  assign w_rx_clr = w_cpu_wr && (addr == A_IN_STAT);
  assign w_tx_clr = w_cpu_wr && (addr == A_OUT_STAT);

  // A clear takes priority over a same-cycle increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_cnt <= '0;
      r_tx_cnt <= '0;
    end else begin
      if (w_rx_clr)                     r_rx_cnt <= '0;
      else if (w_in_push && ~&r_rx_cnt) r_rx_cnt <= r_rx_cnt + 1'b1;
      if (w_tx_clr)                     r_tx_cnt <= '0;
      else if (w_inj && ~&r_tx_cnt)     r_tx_cnt <= r_tx_cnt + 1'b1;
    end
  end
`endif

  always_comb begin
    w_in_status              = '0;
    w_in_status[0]           = !w_in_empty;
    w_in_status[CNT_BITS:1]  = r_in_count;
    w_out_status             = '0;
    w_out_status[0]          = w_out_full;
    w_out_status[CNT_BITS:1] = r_out_count;
`ifdef NIC_STATS_EN
    w_in_status[CNT_W+15:16]  = r_rx_cnt;
    w_out_status[CNT_W+15:16] = r_tx_cnt;
`else
    w_in_status[CNT_W+15:16]  = '0;
    w_out_status[CNT_W+15:16] = '0;
`endif
  end

  always_comb begin
    d_out = '0;
    case (addr)
      A_IN_DATA:  d_out = w_in_empty ? '0 : w_in_head;
      A_IN_STAT:  d_out = w_in_status;
      A_OUT_DATA: d_out = '0;
      A_OUT_STAT: d_out = w_out_status;
      default:    d_out = '0;
    endcase
  end

endmodule
